// File: rtl/fsm_seq_pkg.sv
// Shared types and defaults for the input-code sweep sequencer.
// Holds the state encoding, code width and default counter widths.
package fsm_seq_pkg;

    localparam int CODE_W      = 3;
    localparam int DWELL_W_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWELL  = 2'd1,
        ST_REPORT = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    // Codes wrap modulo 8, so a sweep may run 6,7,0,1.
    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code);
        return code + CODE_W'(1);
    endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// Dwell down-counter: load sets the length (0 treated as 1), expire flags
// the final enabled cycle of the dwell.
module seq_dwell_timer
    import fsm_seq_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic [DWELL_W-1:0] len,
    output logic               expire
);

    logic [DWELL_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= (len == '0) ? DWELL_W'(1) : len;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - DWELL_W'(1);
        end
    end

    assign expire = en && (r_cnt == DWELL_W'(1));

endmodule

// File: rtl/fsm_input_sequencer.sv
// Sweeps a 3-bit code into a controlled FSM, counting cycles its output is
// high per code, and hands each count out through a valid/ready port.
//
//   state  | meaning
//   IDLE   | waiting for start
//   DWELL  | driving b=cur_code, counting outp high cycles
//   REPORT | result presented, waiting for res_ready
//   FINISH | one-cycle done pulse
module fsm_input_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [2:0]         code_lo,
    input  logic [2:0]         code_hi,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:1]         b,
    input  logic               outp,
    output logic               busy,
    output logic               done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2:0]         res_code,
    output logic [CNT_W-1:0]   res_cnt
);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [CODE_W-1:0]   r_cur_code;
    logic [CODE_W-1:0]   r_code_hi;
    logic [DWELL_W-1:0]  r_dwell;
    logic [CNT_W-1:0]    r_hi_cnt;

    logic                w_accept;
    logic                w_handshake;
    logic                w_last_code;
    logic                w_advance;
    logic                w_expire;
    logic                w_timer_load;
    logic [DWELL_W-1:0]  w_timer_len;

    assign w_accept     = (r_state == ST_IDLE) && start && !abort;
    assign w_handshake  = (r_state == ST_REPORT) && res_ready && !abort;
    assign w_last_code  = (r_cur_code == r_code_hi);
    assign w_advance    = w_handshake && !w_last_code;
    assign w_timer_load = w_accept || w_advance;
    assign w_timer_len  = (r_state == ST_IDLE) ? dwell : r_dwell;

    seq_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_timer_load),
        .en     (r_state == ST_DWELL),
        .len    (w_timer_len),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_DWELL;
            ST_DWELL:  if (w_expire) w_state_nxt = ST_REPORT;
            ST_REPORT: if (w_handshake) w_state_nxt = w_last_code ? ST_FINISH : ST_DWELL;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // Abort wins over start and handshake, and skips the done pulse.
        if (abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_code <= '0;
            r_code_hi  <= '0;
            r_dwell    <= '0;
            r_hi_cnt   <= '0;
        end else if (w_accept) begin
            r_cur_code <= code_lo;
            r_code_hi  <= code_hi;
            r_dwell    <= dwell;
            r_hi_cnt   <= '0;
        end else if (w_advance) begin
            r_cur_code <= next_code(r_cur_code);
            r_hi_cnt   <= '0;
        end else if ((r_state == ST_DWELL) && outp && (r_hi_cnt != '1)) begin
            r_hi_cnt <= r_hi_cnt + CNT_W'(1);
        end
    end

    // Outputs decode registered state only; nothing passes through from inputs.
    assign b         = (r_state == ST_DWELL) ? r_cur_code : '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_FINISH);
    assign res_valid = (r_state == ST_REPORT);
    assign res_code  = (r_state == ST_REPORT) ? r_cur_code : '0;
    assign res_cnt   = (r_state == ST_REPORT) ? r_hi_cnt : '0;

endmodule

// File: tb/tb_fsm_input_sequencer.sv
// Directed bench for fsm_input_sequencer: sweeps, wrap, zero dwell,
// back-pressure, abort and mid-sweep reset.
module tb_fsm_input_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] code_lo;
    logic [2:0] code_hi;
    logic [7:0] dwell;
    logic [3:1] b;
    logic       outp;
    logic       busy;
    logic       done;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_code;
    logic [7:0] res_cnt;

    int total = 0;
    int bad   = 0;

    fsm_input_sequencer #(
        .DWELL_W (8),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .code_lo   (code_lo),
        .code_hi   (code_hi),
        .dwell     (dwell),
        .b         (b),
        .outp      (outp),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_code  (res_code),
        .res_cnt   (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b0; outp = 1'b1; res_ready = 1'b1;
        code_lo = 3'd3; code_hi = 3'd4; dwell = 8'd2;
        step();
        step();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        total++; if (b !== 3'd0)         begin bad++; $display("FAIL rst_b got=%0d want=0", b); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", res_valid); end
        total++; if (res_code !== 3'd0)  begin bad++; $display("FAIL rst_code got=%0d want=0", res_code); end
        total++; if (res_cnt !== 8'd0)   begin bad++; $display("FAIL rst_cnt got=%0d want=0", res_cnt); end
        rst = 1'b0; start = 1'b0; outp = 1'b0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%0b want=0", busy); end
    endtask

    task automatic test_full_sweep();
        logic [2:0] exp_code;
        int nres, ndone, dcyc;
        bit idle_seen;
        exp_code = 3'd0; nres = 0; ndone = 0; dcyc = 0; idle_seen = 1'b0;
        code_lo = 3'd0; code_hi = 3'd7; dwell = 8'd24; outp = 1'b1; res_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !idle_seen; cyc++) begin
            if (res_valid) begin
                total++; if (res_code !== exp_code) begin bad++; $display("FAIL full_code got=%0d want=%0d", res_code, exp_code); end
                total++; if (res_cnt !== 8'd24)     begin bad++; $display("FAIL full_cnt code=%0d got=%0d want=24", exp_code, res_cnt); end
                total++; if (dcyc != 24)            begin bad++; $display("FAIL full_dwell_len code=%0d got=%0d want=24", exp_code, dcyc); end
                nres++; dcyc = 0; exp_code = exp_code + 3'd1;
            end else if (done) begin
                ndone++;
            end else if (busy) begin
                dcyc++;
                total++; if (b !== exp_code) begin bad++; $display("FAIL full_b got=%0d want=%0d", b, exp_code); end
            end else begin
                idle_seen = 1'b1;
            end
            if (!idle_seen) step();
        end
        total++; if (nres != 8)       begin bad++; $display("FAIL full_nres got=%0d want=8", nres); end
        total++; if (ndone != 1)      begin bad++; $display("FAIL full_ndone got=%0d want=1", ndone); end
        total++; if (idle_seen != 1)  begin bad++; $display("FAIL full_timeout got=%0b want=1", idle_seen); end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_code;
        int nres, ndone, dcyc;
        bit idle_seen;
        exp_code = 3'd6; nres = 0; ndone = 0; dcyc = 0; idle_seen = 1'b0;
        code_lo = 3'd6; code_hi = 3'd1; dwell = 8'd4; outp = 1'b0; res_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && !idle_seen; cyc++) begin
            if (res_valid) begin
                total++; if (res_code !== exp_code) begin bad++; $display("FAIL wrap_code got=%0d want=%0d", res_code, exp_code); end
                total++; if (res_cnt !== 8'd0)      begin bad++; $display("FAIL wrap_cnt got=%0d want=0", res_cnt); end
                total++; if (dcyc != 4)             begin bad++; $display("FAIL wrap_dwell_len got=%0d want=4", dcyc); end
                nres++; dcyc = 0; exp_code = exp_code + 3'd1;
            end else if (done) begin
                ndone++;
            end else if (busy) begin
                dcyc++;
                total++; if (b !== exp_code) begin bad++; $display("FAIL wrap_b got=%0d want=%0d", b, exp_code); end
            end else begin
                idle_seen = 1'b1;
            end
            if (!idle_seen) step();
        end
        total++; if (nres != 4)      begin bad++; $display("FAIL wrap_nres got=%0d want=4", nres); end
        total++; if (ndone != 1)     begin bad++; $display("FAIL wrap_ndone got=%0d want=1", ndone); end
        total++; if (idle_seen != 1) begin bad++; $display("FAIL wrap_timeout got=%0b want=1", idle_seen); end
    endtask

    task automatic test_dwell_zero();
        code_lo = 3'd5; code_hi = 3'd5; dwell = 8'd0; outp = 1'b0; res_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (b !== 3'd5) begin bad++; $display("FAIL dz_b got=%0d want=5", b); end
        outp = 1'b1;
        step();
        outp = 1'b0;
        total++; if (b !== 3'd0)         begin bad++; $display("FAIL dz_b_after got=%0d want=0", b); end
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL dz_valid got=%0b want=1", res_valid); end
        total++; if (res_code !== 3'd5)  begin bad++; $display("FAIL dz_code got=%0d want=5", res_code); end
        total++; if (res_cnt !== 8'd1)   begin bad++; $display("FAIL dz_cnt got=%0d want=1", res_cnt); end
        step();
        total++; if (done !== 1'b1)      begin bad++; $display("FAIL dz_done got=%0b want=1", done); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL dz_valid_finish got=%0b want=0", res_valid); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL dz_done_one_cycle got=%0b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dz_idle got=%0b want=0", busy); end
    endtask

    task automatic test_back_pressure();
        int ndone;
        ndone = 0;
        code_lo = 3'd2; code_hi = 3'd3; dwell = 8'd3; outp = 1'b1; res_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (b !== 3'd2) begin bad++; $display("FAIL bp_dwell_b cyc=%0d got=%0d want=2", i, b); end
            step();
        end
        for (int i = 0; i < 10; i++) begin
            total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0b want=1", i, res_valid); end
            total++; if (res_code !== 3'd2)  begin bad++; $display("FAIL bp_code cyc=%0d got=%0d want=2", i, res_code); end
            total++; if (res_cnt !== 8'd3)   begin bad++; $display("FAIL bp_cnt cyc=%0d got=%0d want=3", i, res_cnt); end
            total++; if (b !== 3'd0)         begin bad++; $display("FAIL bp_b cyc=%0d got=%0d want=0", i, b); end
            outp = (i % 2 == 0);
            start = (i == 3);
            code_lo = 3'd7;
            if (i == 9) begin
                res_ready = 1'b1;
                outp = 1'b0;
            end
            step();
        end
        start = 1'b0;
        total++; if (b !== 3'd3)         begin bad++; $display("FAIL bp_resume_b got=%0d want=3", b); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_resume_valid got=%0b want=0", res_valid); end
        for (int i = 0; i < 30; i++) begin
            if (res_valid) begin
                total++; if (res_code !== 3'd3) begin bad++; $display("FAIL bp_code2 got=%0d want=3", res_code); end
                total++; if (res_cnt !== 8'd0)  begin bad++; $display("FAIL bp_cnt2 got=%0d want=0", res_cnt); end
            end
            if (done) ndone++;
            step();
        end
        total++; if (ndone != 1)    begin bad++; $display("FAIL bp_ndone got=%0d want=1", ndone); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%0b want=0", busy); end
    endtask

    task automatic test_abort();
        int n;
        code_lo = 3'd0; code_hi = 3'd7; dwell = 8'd5; outp = 1'b1; res_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (b !== 3'd2 && n < 100) begin
            step();
            n++;
        end
        total++; if (b !== 3'd2) begin bad++; $display("FAIL ab_reach_code2 got=%0d want=2", b); end
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL ab_busy got=%0b want=0", busy); end
        total++; if (b !== 3'd0)         begin bad++; $display("FAIL ab_b got=%0d want=0", b); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL ab_done got=%0b want=0", done); end
        for (int i = 0; i < 60; i++) begin
            total++; if ((done | res_valid | busy) !== 1'b0) begin bad++; $display("FAIL ab_quiet cyc=%0d done=%0b valid=%0b busy=%0b want=0", i, done, res_valid, busy); end
            step();
        end
        code_lo = 3'd4; code_hi = 3'd4; dwell = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (b !== 3'd4) begin bad++; $display("FAIL ab_restart_b got=%0d want=4", b); end
        step();
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL ab_restart_valid got=%0b want=1", res_valid); end
        total++; if (res_code !== 3'd4)  begin bad++; $display("FAIL ab_restart_code got=%0d want=4", res_code); end
        total++; if (res_cnt !== 8'd2)   begin bad++; $display("FAIL ab_restart_cnt got=%0d want=2", res_cnt); end
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ab_restart_done got=%0b want=1", done); end
        step();
    endtask

    task automatic test_reset_mid_report();
        code_lo = 3'd1; code_hi = 3'd3; dwell = 8'd2; outp = 1'b1; res_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL rr_valid got=%0b want=1", res_valid); end
        total++; if (res_cnt !== 8'd2)   begin bad++; $display("FAIL rr_cnt got=%0d want=2", res_cnt); end
        rst = 1'b1; start = 1'b1; code_lo = 3'd6;
        step();
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rr_busy got=%0b want=0", busy); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rr_valid_after got=%0b want=0", res_valid); end
        total++; if (res_code !== 3'd0)  begin bad++; $display("FAIL rr_code got=%0d want=0", res_code); end
        total++; if (res_cnt !== 8'd0)   begin bad++; $display("FAIL rr_cnt_after got=%0d want=0", res_cnt); end
        total++; if (b !== 3'd0)         begin bad++; $display("FAIL rr_b got=%0d want=0", b); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL rr_done got=%0b want=0", done); end
        rst = 1'b0; start = 1'b0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_start_ignored got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rr_no_done got=%0b want=0", done); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; outp = 1'b0; res_ready = 1'b0;
        code_lo = 3'd0; code_hi = 3'd0; dwell = 8'd0;
        test_reset();
        test_full_sweep();
        test_wrap();
        test_dwell_zero();
        test_back_pressure();
        test_abort();
        test_reset_mid_report();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
